npu_csr_ctrl: RTL and testbench



---
 rtl/npu_csr_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_npu_csr_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_csr_ctrl.sv
// NPU control/status register block: AXI4-Lite slave with NPU control, interrupt
// aggregation and per-channel DMA descriptor registers.
module npu_csr_ctrl #(
  parameter int          NUM_DMA_CH  = 4,
  parameter int          PE_ROWS     = 16,
  parameter int          PE_COLS     = 16,
  parameter logic [31:0] VERSION     = 32'h00020000,
  parameter int          AXIL_ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXIL_ADDR_W-1:0]  s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [31:0]             s_axil_wdata,
  input  logic [3:0]              s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [AXIL_ADDR_W-1:0]  s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [31:0]             s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic                    npu_enable,
  output logic                    npu_start,
  input  logic                    npu_busy,
  input  logic                    npu_done,
  input  logic                    npu_error,
  input  logic [3:0]              ctrl_state,
  output logic [NUM_DMA_CH-1:0]   dma_start,
  output logic [32*NUM_DMA_CH-1:0] dma_src,
  output logic [32*NUM_DMA_CH-1:0] dma_dst,
  output logic [24*NUM_DMA_CH-1:0] dma_len,
  output logic [8*NUM_DMA_CH-1:0]  dma_flags,
  input  logic [NUM_DMA_CH-1:0]   dma_busy,
  input  logic [NUM_DMA_CH-1:0]   dma_done,
  input  logic [NUM_DMA_CH-1:0]   dma_error,
  output logic                    irq
);

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] irq_mask_f();
    logic [31:0] m;
    m = 32'h0000_0003;
    for (int c = 0; c < NUM_DMA_CH; c++) begin
      m[8+c]  = 1'b1;
      m[16+c] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [31:0] IRQ_MASK = irq_mask_f();

  // Ready outputs stay low until the first clock edge after reset release.
  logic        rdy_q;
  logic        aw_held_q, w_held_q;
  logic [11:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic        ctrl_en_q, ctrl_en_d;
  logic [31:0] irq_en_q, irq_en_d;
  logic [31:0] irq_status_q, irq_status_d;
  logic        npu_start_q, npu_start_d;
  logic [NUM_DMA_CH-1:0] dma_start_q, dma_start_d;
  logic [31:0] src_q   [NUM_DMA_CH];
  logic [31:0] src_d   [NUM_DMA_CH];
  logic [31:0] dst_q   [NUM_DMA_CH];
  logic [31:0] dst_d   [NUM_DMA_CH];
  logic [23:0] len_q   [NUM_DMA_CH];
  logic [23:0] len_d   [NUM_DMA_CH];
  logic [7:0]  flags_q [NUM_DMA_CH];
  logic [7:0]  flags_d [NUM_DMA_CH];

  logic        wr_fire, wr_err, rd_err;
  logic [31:0] wr_mask, irq_set, irq_clr, rd_data;
  logic [2:0]  wr_ch, rd_ch;
  logic [11:0] ar_addr;
  logic        aw_hs, w_hs, ar_hs;

  assign s_axil_awready = rdy_q && !aw_held_q && !bvalid_q;
  assign s_axil_wready  = rdy_q && !w_held_q && !bvalid_q;
  assign s_axil_arready = rdy_q && !rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  assign aw_hs   = s_axil_awvalid && s_axil_awready;
  assign w_hs    = s_axil_wvalid && s_axil_wready;
  assign ar_hs   = s_axil_arvalid && s_axil_arready;
  assign wr_fire = aw_held_q && w_held_q;
  assign wr_mask = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
  assign wr_ch   = aw_addr_q[7:5];
  assign ar_addr = s_axil_araddr[11:0];
  assign rd_ch   = ar_addr[7:5];

  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    irq_en_d    = irq_en_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    flags_d     = flags_q;
    npu_start_d = 1'b0;
    dma_start_d = '0;
    irq_clr     = '0;
    wr_err      = 1'b1;
    if (wr_fire) begin
      if (aw_addr_q[11:8] == 4'h1) begin
        for (int c = 0; c < NUM_DMA_CH; c++) begin
          if (wr_ch == 3'(c)) begin
            case (aw_addr_q[4:0])
              5'h00: begin
                wr_err = 1'b0;
                if (w_strb_q[0] && w_data_q[0]) dma_start_d[c] = 1'b1;
                if (w_strb_q[1]) flags_d[c] = w_data_q[15:8];
              end
              5'h08: begin
                wr_err   = 1'b0;
                src_d[c] = (src_q[c] & ~wr_mask) | (w_data_q & wr_mask);
              end
              5'h0C: begin
                wr_err   = 1'b0;
                dst_d[c] = (dst_q[c] & ~wr_mask) | (w_data_q & wr_mask);
              end
              5'h10: begin
                wr_err   = 1'b0;
                len_d[c] = (len_q[c] & ~wr_mask[23:0]) | (w_data_q[23:0] & wr_mask[23:0]);
              end
              default: ;
            endcase
          end
        end
      end else begin
        case (aw_addr_q)
          12'h000: begin
            wr_err = 1'b0;
            if (w_strb_q[0]) begin
              ctrl_en_d   = w_data_q[0];
              npu_start_d = w_data_q[1] && w_data_q[0];
            end
          end
          12'h008: begin
            wr_err   = 1'b0;
            irq_en_d = (irq_en_q & ~wr_mask) | (w_data_q & wr_mask);
          end
          12'h00C: begin
            wr_err  = 1'b0;
            irq_clr = w_data_q & wr_mask;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    irq_set    = '0;
    irq_set[0] = npu_done;
    irq_set[1] = npu_error;
    for (int c = 0; c < NUM_DMA_CH; c++) begin
      irq_set[8+c]  = dma_done[c];
      irq_set[16+c] = dma_error[c];
    end
  end

  // Hardware sets are OR-ed in after the W1C clear so a coincident event survives.
  assign irq_status_d = ((irq_status_q & ~irq_clr) | irq_set) & IRQ_MASK;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    if (ar_addr[11:8] == 4'h1) begin
      for (int c = 0; c < NUM_DMA_CH; c++) begin
        if (rd_ch == 3'(c)) begin
          rd_err = 1'b0;
          case (ar_addr[4:0])
            5'h00:   rd_data = {16'h0, flags_q[c], 8'h0};
            5'h04:   rd_data = {30'h0, irq_status_q[8+c], dma_busy[c]};
            5'h08:   rd_data = src_q[c];
            5'h0C:   rd_data = dst_q[c];
            5'h10:   rd_data = {8'h0, len_q[c]};
            default: rd_err = 1'b1;
          endcase
        end
      end
    end else begin
      rd_err = 1'b0;
      case (ar_addr)
        12'h000: rd_data = {31'h0, ctrl_en_q};
        12'h004: rd_data = {24'h0, ctrl_state, 2'b00, npu_done, npu_busy};
        12'h008: rd_data = irq_en_q;
        12'h00C: rd_data = irq_status_q;
        12'h010: rd_data = VERSION;
        12'h014: rd_data = {16'(PE_ROWS), 16'(PE_COLS)};
        default: rd_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q        <= 1'b0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OK;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OK;
      rdata_q      <= '0;
      ctrl_en_q    <= 1'b0;
      irq_en_q     <= '0;
      irq_status_q <= '0;
      npu_start_q  <= 1'b0;
      dma_start_q  <= '0;
      for (int c = 0; c < NUM_DMA_CH; c++) begin
        src_q[c]   <= '0;
        dst_q[c]   <= '0;
        len_q[c]   <= '0;
        flags_q[c] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s_axil_awaddr[11:0];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if (wr_fire) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OK;
      end else if (bvalid_q && s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OK;
      end else if (rvalid_q && s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
      ctrl_en_q    <= ctrl_en_d;
      irq_en_q     <= irq_en_d;
      irq_status_q <= irq_status_d;
      npu_start_q  <= npu_start_d;
      dma_start_q  <= dma_start_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      flags_q      <= flags_d;
    end
  end

  assign npu_enable = ctrl_en_q;
  assign npu_start  = npu_start_q;
  assign dma_start  = dma_start_q;
  assign irq        = |(irq_status_q & irq_en_q);

  for (genvar gi = 0; gi < NUM_DMA_CH; gi++) begin : g_ch
    assign dma_src[32*gi +: 32]  = src_q[gi];
    assign dma_dst[32*gi +: 32]  = dst_q[gi];
    assign dma_len[24*gi +: 24]  = len_q[gi];
    assign dma_flags[8*gi +: 8]  = flags_q[gi];
  end

  // Only addr[11:0] takes part in decode.
  if (AXIL_ADDR_W > 12) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{s_axil_awaddr[AXIL_ADDR_W-1:12], s_axil_araddr[AXIL_ADDR_W-1:12]};
  end

endmodule

// File: tb/tb_npu_csr_ctrl.sv
// Self-checking bench for npu_csr_ctrl: directed vector table, hand-timed corner
// sequences and a randomized phase against a register-map reference model.
module tb_npu_csr_ctrl;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        npu_enable, npu_start, irq;
  logic        npu_busy = 0, npu_done = 0, npu_error = 0;
  logic [3:0]  ctrl_state = '0;
  logic [NCH-1:0] dma_start;
  logic [NCH-1:0] dma_busy = '0, dma_done = '0, dma_error = '0;
  logic [32*NCH-1:0] dma_src, dma_dst;
  logic [24*NCH-1:0] dma_len;
  logic [8*NCH-1:0]  dma_flags;

  npu_csr_ctrl #(.NUM_DMA_CH(NCH)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .npu_enable(npu_enable), .npu_start(npu_start), .npu_busy(npu_busy),
    .npu_done(npu_done), .npu_error(npu_error), .ctrl_state(ctrl_state),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_flags(dma_flags), .dma_busy(dma_busy), .dma_done(dma_done), .dma_error(dma_error),
    .irq(irq)
  );

  int checks = 0;
  int errors = 0;
  int npu_cnt = 0;
  int dma_cnt [NCH];

  always @(negedge clk) begin
    if (npu_start) npu_cnt <= npu_cnt + 1;
    for (int c = 0; c < NCH; c++) if (dma_start[c]) dma_cnt[c] <= dma_cnt[c] + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input logic [31:0] a);
    checks++;
    errors++;
    $display("FAIL %s: got no response expected a response (addr %h)", name, a);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_ok, w_ok, got;
    logic a_r, w_r;
    aw_ok = 0; w_ok = 0; got = 0; resp = 2'b11;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
    for (int n = 0; n < 50 && !(aw_ok && w_ok); n++) begin
      @(negedge clk); a_r = awready; w_r = wready;
      @(posedge clk); #1;
      if (awvalid && a_r) begin aw_ok = 1; awvalid = 0; end
      if (wvalid && w_r) begin w_ok = 1; wvalid = 0; end
    end
    for (int n = 0; n < 50 && aw_ok && w_ok && !got; n++) begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; got = 1; end
      @(posedge clk); #1;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    if (!got) timeout_fail("wr_timeout", a);
    $display("WR %h <= %h strb %h resp %b", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit ok, got;
    logic ar_r;
    ok = 0; got = 0; d = '0; r = 2'b11;
    araddr = a; arvalid = 1; rready = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ar_r = arready;
      @(posedge clk); #1;
      if (ar_r) begin ok = 1; arvalid = 0; end
    end
    for (int n = 0; n < 50 && ok && !got; n++) begin
      @(negedge clk);
      if (rvalid) begin d = rdata; r = rresp; got = 1; end
      @(posedge clk); #1;
    end
    arvalid = 0; rready = 0;
    if (!got) timeout_fail("rd_timeout", a);
    $display("RD %h => %h resp %b", a, d, r);
  endtask

  // Reference model: register map state
  logic        m_en;
  logic [31:0] m_ien, m_ist;
  logic [31:0] m_src [NCH];
  logic [31:0] m_dst [NCH];
  logic [23:0] m_len [NCH];
  logic [7:0]  m_flg [NCH];

  task automatic model_reset();
    m_en = 0; m_ien = '0; m_ist = '0;
    for (int c = 0; c < NCH; c++) begin
      m_src[c] = '0; m_dst[c] = '0; m_len[c] = '0; m_flg[c] = '0;
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit exp_npu,
                             output logic [NCH-1:0] exp_dma);
    logic [31:0] m, t;
    int x, ch, off;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    x = int'(a & 32'hFFF);
    resp = 2'b00; exp_npu = 0; exp_dma = '0;
    if (x >= 'h100 && x < 'h100 + 'h20 * NCH) begin
      ch = (x - 'h100) / 'h20;
      off = (x - 'h100) % 'h20;
      case (off)
        0: begin
          if (s[0] && d[0]) exp_dma[ch] = 1'b1;
          if (s[1]) m_flg[ch] = d[15:8];
        end
        8:  m_src[ch] = (m_src[ch] & ~m) | (d & m);
        12: m_dst[ch] = (m_dst[ch] & ~m) | (d & m);
        16: begin
          t = ({8'h0, m_len[ch]} & ~m) | (d & m);
          m_len[ch] = t[23:0];
        end
        default: resp = 2'b10;
      endcase
    end else begin
      case (x)
        'h000: if (s[0]) begin m_en = d[0]; exp_npu = d[1] && m_en; end
        'h008: m_ien = (m_ien & ~m) | (d & m);
        'h00C: m_ist = m_ist & ~(d & m);
        default: resp = 2'b10;
      endcase
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int x, ch, off;
    x = int'(a & 32'hFFF);
    d = '0; r = 2'b00;
    if (x >= 'h100 && x < 'h100 + 'h20 * NCH) begin
      ch = (x - 'h100) / 'h20;
      off = (x - 'h100) % 'h20;
      case (off)
        0:  d = {16'h0, m_flg[ch], 8'h0};
        4:  d = {30'h0, m_ist[8+ch], dma_busy[ch]};
        8:  d = m_src[ch];
        12: d = m_dst[ch];
        16: d = {8'h0, m_len[ch]};
        default: r = 2'b10;
      endcase
    end else begin
      case (x)
        'h000: d = {31'h0, m_en};
        'h004: d = {24'h0, ctrl_state, 2'b00, npu_done, npu_busy};
        'h008: d = m_ien;
        'h00C: d = m_ist;
        'h010: d = 32'h0002_0000;
        'h014: d = 32'h0010_0010;
        default: r = 2'b10;
      endcase
    end
  endtask

  task automatic pulse_irq();
    int k, c;
    k = $urandom_range(0, 3);
    c = $urandom_range(0, NCH - 1);
    @(posedge clk); #1;
    case (k)
      0: npu_done = 1;
      1: npu_error = 1;
      2: dma_done[c] = 1;
      default: dma_error[c] = 1;
    endcase
    @(posedge clk); #1;
    npu_done = 0; npu_error = 0; dma_done = '0; dma_error = '0;
    case (k)
      0: m_ist[0] = 1;
      1: m_ist[1] = 1;
      2: m_ist[8+c] = 1;
      default: m_ist[16+c] = 1;
    endcase
    $display("IRQ source %0d channel %0d pulsed", k, c);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  logic [31:0] rd_d, a, d, exp_d;
  logic [1:0]  rsp, exp_r;
  bit          exp_npu;
  logic [NCH-1:0] exp_dma;
  int          npu_before, dma_before [NCH];
  logic [31:0] dma_act, dma_exp;
  logic [31:0] glist [8];

  initial begin
    tbl[0]  = '{1'b0, 32'h010, 32'h0, 4'h0, 32'h0002_0000, 2'b00};
    tbl[1]  = '{1'b0, 32'h014, 32'h0, 4'h0, 32'h0010_0010, 2'b00};
    tbl[2]  = '{1'b0, 32'h000, 32'h0, 4'h0, 32'h0, 2'b00};
    tbl[3]  = '{1'b0, 32'h004, 32'h0, 4'h0, 32'h0, 2'b00};
    tbl[4]  = '{1'b0, 32'h0F0, 32'h0, 4'h0, 32'h0, 2'b10};
    tbl[5]  = '{1'b1, 32'h0F0, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10};
    tbl[6]  = '{1'b1, 32'h008, 32'h1234_5678, 4'h5, 32'h0, 2'b00};
    tbl[7]  = '{1'b0, 32'h008, 32'h0, 4'h0, 32'h0034_0078, 2'b00};
    tbl[8]  = '{1'b1, 32'h010, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10};
    tbl[9]  = '{1'b0, 32'h010, 32'h0, 4'h0, 32'h0002_0000, 2'b00};
    tbl[10] = '{1'b1, 32'h168, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00};
    tbl[11] = '{1'b1, 32'h170, 32'hFF12_3456, 4'hF, 32'h0, 2'b00};
    tbl[12] = '{1'b0, 32'h170, 32'h0, 4'h0, 32'h0012_3456, 2'b00};
    tbl[13] = '{1'b0, 32'h168, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00};
    tbl[14] = '{1'b1, 32'h120, 32'h0000_AB01, 4'h2, 32'h0, 2'b00};
    tbl[15] = '{1'b0, 32'h120, 32'h0, 4'h0, 32'h0000_AB00, 2'b00};
    tbl[16] = '{1'b0, 32'h180, 32'h0, 4'h0, 32'h0, 2'b10};
    tbl[17] = '{1'b1, 32'h124, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10};
    tbl[18] = '{1'b0, 32'h00C, 32'h0, 4'h0, 32'h0, 2'b00};
    tbl[19] = '{1'b1, 32'h14C, 32'h0000_0011, 4'h1, 32'h0, 2'b00};
    tbl[20] = '{1'b0, 32'h14C, 32'h0, 4'h0, 32'h0000_0011, 2'b00};
    glist = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014, 32'h0F0, 32'h1000_0008};
    for (int c = 0; c < NCH; c++) dma_cnt[c] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'h1);
    check("rst_wready", 32'(wready), 32'h1);
    check("rst_arready", 32'(arready), 32'h1);
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_enable", 32'(npu_enable), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_src3", dma_src[96 +: 32], 32'h0);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, rsp);
        check($sformatf("tbl%0d_bresp", i), 32'(rsp), 32'(tbl[i].exp_resp));
      end else begin
        axi_read(tbl[i].addr, rd_d, rsp);
        check($sformatf("tbl%0d_rdata", i), rd_d, tbl[i].exp_data);
        check($sformatf("tbl%0d_rresp", i), 32'(rsp), 32'(tbl[i].exp_resp));
      end
    end
    check("tbl_src3", dma_src[96 +: 32], 32'hDEAD_BEEF);
    check("tbl_len3", 32'(dma_len[72 +: 24]), 32'h0012_3456);
    check("tbl_flags1", 32'(dma_flags[8 +: 8]), 32'h0000_00AB);
    check("tbl_dst2", dma_dst[64 +: 32], 32'h0000_0011);
    check("tbl_dma_starts", 32'(dma_cnt[0] + dma_cnt[1] + dma_cnt[2] + dma_cnt[3]), 32'h0);
    check("tbl_npu_starts", 32'(npu_cnt), 32'h0);

    // W leads AW by three cycles
    npu_before = npu_cnt;
    wdata = 32'h3; wstrb = 4'hF; wvalid = 1; bready = 1;
    @(posedge clk); #1; wvalid = 0;
    repeat (2) begin
      @(negedge clk);
      check("wfirst_no_bvalid", 32'(bvalid), 32'h0);
      @(posedge clk); #1;
    end
    awaddr = 32'h000; awvalid = 1;
    @(posedge clk); #1; awvalid = 0;
    @(negedge clk);
    check("wfirst_commit_latency", 32'(bvalid), 32'h0);
    @(negedge clk);
    check("wfirst_bvalid", 32'(bvalid), 32'h1);
    check("wfirst_bresp", 32'(bresp), 32'h0);
    check("wfirst_enable", 32'(npu_enable), 32'h1);
    @(posedge clk); #1; bready = 0;
    @(negedge clk);
    check("wfirst_start_pulses", 32'(npu_cnt - npu_before), 32'h1);
    axi_read(32'h000, rd_d, rsp);
    check("wfirst_ctrl_rd", rd_d, 32'h1);

    // DMA error interrupt and W1C racing a fresh set
    axi_write(32'h008, 32'h0004_0000, 4'hF, rsp);
    @(posedge clk); #1; dma_error[2] = 1;
    @(posedge clk); #1; dma_error[2] = 0;
    @(negedge clk);
    check("dmaerr_irq", 32'(irq), 32'h1);
    axi_read(32'h00C, rd_d, rsp);
    check("dmaerr_status", rd_d, 32'h0004_0000);
    @(posedge clk); #1;
    awaddr = 32'h00C; wdata = 32'h0004_0000; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(posedge clk); #1; awvalid = 0; wvalid = 0; dma_error[2] = 1;
    @(posedge clk); #1; dma_error[2] = 0;
    @(negedge clk);
    check("w1c_race_bvalid", 32'(bvalid), 32'h1);
    @(posedge clk); #1; bready = 0;
    axi_read(32'h00C, rd_d, rsp);
    check("w1c_race_status", rd_d, 32'h0004_0000);
    axi_write(32'h00C, 32'h0004_0000, 4'hF, rsp);
    @(negedge clk);
    check("w1c_clear_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;

    // Read response back-pressure
    araddr = 32'h010; arvalid = 1; rready = 0;
    @(posedge clk); #1; arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rvalid", i), 32'(rvalid), 32'h1);
      check($sformatf("stall%0d_rdata", i), rdata, 32'h0002_0000);
      check($sformatf("stall%0d_arready", i), 32'(arready), 32'h0);
    end
    rready = 1;
    @(posedge clk); #1; rready = 0;
    @(negedge clk);
    check("stall_release_rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;

    // Reset while only AW is held
    awaddr = 32'h008; awvalid = 1;
    @(posedge clk); #1; awvalid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    @(posedge clk); #1;
    wdata = 32'h0000_00A5; wstrb = 4'hF; wvalid = 1; bready = 1;
    @(posedge clk); #1; wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_abort%0d_bvalid", i), 32'(bvalid), 32'h0);
    end
    @(posedge clk); #1;
    awaddr = 32'h008; awvalid = 1;
    @(posedge clk); #1; awvalid = 0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_bvalid", 32'(bvalid), 32'h1);
    check("post_rst_bresp", 32'(bresp), 32'h0);
    @(posedge clk); #1; bready = 0;
    axi_read(32'h008, rd_d, rsp);
    check("post_rst_irq_en", rd_d, 32'h0000_00A5);
    check("post_rst_enable", 32'(npu_enable), 32'h0);
    m_ien = 32'h0000_00A5;

    // Randomized traffic against the reference model
    for (int t = 0; t < 300; t++) begin
      npu_busy = 1'($urandom_range(0, 1));
      ctrl_state = 4'($urandom);
      dma_busy = NCH'($urandom);
      if ($urandom_range(0, 3) == 0) pulse_irq();
      if ($urandom_range(0, 1) == 1) a = glist[$urandom_range(0, 7)];
      else a = 32'h100 + 32'h20 * $urandom_range(0, NCH) + 32'h4 * $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wstrb = 4'($urandom);
        npu_before = npu_cnt;
        for (int c = 0; c < NCH; c++) dma_before[c] = dma_cnt[c];
        model_write(a, d, wstrb, exp_r, exp_npu, exp_dma);
        axi_write(a, d, wstrb, rsp);
        @(negedge clk);
        check($sformatf("rnd%0d_bresp", t), 32'(rsp), 32'(exp_r));
        check($sformatf("rnd%0d_npu_start", t), 32'(npu_cnt - npu_before), 32'(exp_npu));
        dma_act = '0; dma_exp = '0;
        for (int c = 0; c < NCH; c++) begin
          dma_act[4*c +: 4] = 4'(dma_cnt[c] - dma_before[c]);
          dma_exp[4*c +: 4] = 4'(exp_dma[c]);
        end
        check($sformatf("rnd%0d_dma_start", t), dma_act, dma_exp);
        @(posedge clk); #1;
      end else begin
        model_read(a, exp_d, exp_r);
        axi_read(a, rd_d, rsp);
        check($sformatf("rnd%0d_rdata", t), rd_d, exp_d);
        check($sformatf("rnd%0d_rresp", t), 32'(rsp), 32'(exp_r));
      end
      check($sformatf("rnd%0d_irq", t), 32'(irq), 32'(|(m_ist & m_ien)));
    end

    @(negedge clk);
    check("final_enable", 32'(npu_enable), 32'(m_en));
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("final_src%0d", c), dma_src[32*c +: 32], m_src[c]);
      check($sformatf("final_dst%0d", c), dma_dst[32*c +: 32], m_dst[c]);
      check($sformatf("final_len%0d", c), 32'(dma_len[24*c +: 24]), 32'(m_len[c]));
      check($sformatf("final_flags%0d", c), 32'(dma_flags[8*c +: 8]), 32'(m_flg[c]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
